// File: rtl/ether_firewall.sv
// ether_firewall: strips the 14-byte Ethernet header from an MSB-first RMII dibit stream
// and forwards the payload of frames addressed to MAC_ADDR. Defining
// ETHER_FIREWALL_BROADCAST_EN also accepts the all-ones broadcast destination.
module ether_firewall #(
    parameter logic [47:0] MAC_ADDR   = 48'h69_69_5A_06_54_91,
    parameter int          HDR_DIBITS = 56
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       frame_ok,
    output logic       frame_drop
);
    typedef enum logic [2:0] {IDLE, DEST, HDR, PASS, DROP} state_t;
    localparam logic [5:0] DEST_LAST = 6'd23;
    localparam logic [5:0] HDR_LAST  = 6'(HDR_DIBITS - 1);
    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_mac_hit;
    logic        r_seen_gap;
    logic [47:0] w_mac_sh;
    logic        w_mac_eq;
    logic        w_accept;
    assign w_mac_sh = MAC_ADDR << {r_cnt, 1'b0};
    assign w_mac_eq = axiid == w_mac_sh[47:46];
`ifdef ETHER_FIREWALL_BROADCAST_EN
    logic r_bc_hit;
    assign w_accept = r_mac_hit | r_bc_hit;
`else
    assign w_accept = r_mac_hit;
`endif
    // Frame FSM: match destination, skip header, forward or discard payload, report frame end.
    // r_seen_gap keeps a frame already in flight at reset from being parsed as a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_mac_hit  <= 1'b1;
            r_seen_gap <= 1'b0;
            axiov      <= 1'b0;
            axiod      <= 2'b00;
            frame_ok   <= 1'b0;
            frame_drop <= 1'b0;
`ifdef ETHER_FIREWALL_BROADCAST_EN
            r_bc_hit   <= 1'b1;
`endif
        end else begin
            axiov      <= 1'b0;
            frame_ok   <= 1'b0;
            frame_drop <= 1'b0;
            if (!axiiv) begin
                r_seen_gap <= 1'b1;
                r_state    <= IDLE;
                r_cnt      <= '0;
                r_mac_hit  <= 1'b1;
                frame_ok   <= r_state == PASS;
                frame_drop <= r_state != PASS && r_state != IDLE;
`ifdef ETHER_FIREWALL_BROADCAST_EN
                r_bc_hit   <= 1'b1;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        if (r_seen_gap) begin
                            r_state   <= DEST;
                            r_cnt     <= 6'd1;
                            r_mac_hit <= w_mac_eq;
`ifdef ETHER_FIREWALL_BROADCAST_EN
                            r_bc_hit  <= axiid == 2'b11;
`endif
                        end else begin
                            r_state <= DROP;
                        end
                    end
                    DEST: begin
                        r_cnt     <= r_cnt + 6'd1;
                        r_mac_hit <= r_mac_hit & w_mac_eq;
`ifdef ETHER_FIREWALL_BROADCAST_EN
                        r_bc_hit  <= r_bc_hit & (axiid == 2'b11);
`endif
                        if (r_cnt == DEST_LAST) r_state <= HDR;
                    end
                    HDR: begin
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == HDR_LAST) r_state <= w_accept ? PASS : DROP;
                    end
                    PASS: begin
                        axiov <= 1'b1;
                        axiod <= axiid;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ether_firewall.sv
// tb_ether_firewall: randomized and directed frames against a frame-level reference model.
module tb_ether_firewall;
    localparam logic [47:0] MAC = 48'h69_69_5A_06_54_91;
    localparam int HDR = 56;
`ifdef ETHER_FIREWALL_BROADCAST_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       axiiv = 1'b0;
    logic [1:0] axiid = 2'b00;
    logic       axiov;
    logic [1:0] axiod;
    logic       frame_ok;
    logic       frame_drop;
    int errors = 0;
    int checks = 0;
    logic [1:0] fd[$];
    logic [1:0] got[$];
    logic [1:0] exp_q[$];
    int n_ok, n_drop, first_ov, ov_breaks;
    bit e_ok, e_drop;

    ether_firewall dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .axiov(axiov), .axiod(axiod), .frame_ok(frame_ok), .frame_drop(frame_drop)
    );

    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic add_byte(input logic [7:0] b);
        fd.push_back(b[7:6]);
        fd.push_back(b[5:4]);
        fd.push_back(b[3:2]);
        fd.push_back(b[1:0]);
    endtask

    task automatic build(input logic [47:0] dest, input int pay_bytes, input int extra);
        fd.delete();
        for (int i = 0; i < 6; i++) add_byte(dest[47-8*i -: 8]);
        for (int i = 0; i < 8; i++) add_byte(8'($urandom));
        for (int i = 0; i < pay_bytes; i++) add_byte(8'($urandom));
        for (int i = 0; i < extra; i++) fd.push_back(2'($urandom));
    endtask

    // Reference: reassemble the destination address, decide, and list the payload dibits.
    task automatic model(input int rst_at);
        logic [47:0] dest;
        bit acc;
        int stop;
        dest = '0;
        exp_q.delete();
        for (int i = 0; i < 24 && i < fd.size(); i++) dest = {dest[45:0], fd[i]};
        acc = fd.size() >= HDR && (dest == MAC || (BC && dest == '1));
        stop = (rst_at >= 0 && rst_at < fd.size()) ? rst_at : fd.size();
        if (acc) for (int i = HDR; i < stop; i++) exp_q.push_back(fd[i]);
        e_ok = acc && rst_at < 0;
        e_drop = !acc && rst_at < 0;
    endtask

    // Dibit k is driven during the cycle before edge k and sampled 1 time unit after it.
    task automatic run_frame(input int rst_at, input int gap);
        bit prev_ov;
        got.delete();
        n_ok = 0;
        n_drop = 0;
        first_ov = -1;
        ov_breaks = 0;
        prev_ov = 1'b0;
        for (int k = 0; k < fd.size() + gap; k++) begin
            axiiv = k < fd.size();
            axiid = k < fd.size() ? fd[k] : 2'b00;
            rst = k == rst_at;
            @(posedge clk);
            #1;
            if (axiov) begin
                if (!prev_ov && got.size() > 0) ov_breaks++;
                if (first_ov < 0) first_ov = k;
                got.push_back(axiod);
            end
            prev_ov = axiov;
            n_ok += int'(frame_ok);
            n_drop += int'(frame_drop);
        end
        rst = 1'b0;
    endtask

    function automatic int first_diff();
        if (got.size() != exp_q.size()) return -2;
        foreach (got[i]) if (got[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        axiiv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({axiov, axiod, frame_ok, frame_drop} !== 5'b0) begin
            errors++;
            $display("FAIL reset_values: got ov=%b d=%b ok=%b drop=%b, want all 0", axiov, axiod, frame_ok, frame_drop);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({axiov, frame_ok, frame_drop} !== 3'b0) begin
                errors++;
                $display("FAIL idle_quiet[%0d]: got ov=%b ok=%b drop=%b, want 0", i, axiov, frame_ok, frame_drop);
            end
        end
    endtask

    task automatic test_match_vector();
        logic [1:0] vec[16] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00,
                                2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
        build(MAC, 0, 0);
        add_byte(8'hA5);
        add_byte(8'h3C);
        add_byte(8'h0F);
        add_byte(8'hF0);
        run_frame(-1, 3);
        checks++;
        if (got.size() != 16) begin
            errors++;
            $display("FAIL vec_len: got %0d dibits, want 16", got.size());
        end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== vec[i]) begin
                errors++;
                $display("FAIL vec_dibit[%0d]: got %b, want %b", i, got[i], vec[i]);
            end
        end
        checks++;
        if (first_ov != HDR) begin
            errors++;
            $display("FAIL vec_latency: first axiov at step %0d, want %0d", first_ov, HDR);
        end
        checks++;
        if (n_ok != 1 || n_drop != 0 || ov_breaks != 0) begin
            errors++;
            $display("FAIL vec_pulses: ok=%0d drop=%0d breaks=%0d, want 1 0 0", n_ok, n_drop, ov_breaks);
        end
    endtask

    task automatic test_mismatch();
        build(48'h69_69_5A_06_54_90, 100, 0);
        run_frame(-1, 3);
        checks++;
        if (got.size() != 0 || n_ok != 0 || n_drop != 1) begin
            errors++;
            $display("FAIL mismatch: out=%0d ok=%0d drop=%0d, want 0 0 1", got.size(), n_ok, n_drop);
        end
    endtask

    task automatic test_broadcast();
        int want_len;
        build('1, 4, 0);
        run_frame(-1, 3);
        model(-1);
        want_len = BC ? 16 : 0;
        checks++;
        if (got.size() != want_len || first_diff() != -1) begin
            errors++;
            $display("FAIL broadcast_out: got %0d dibits (diff %0d), want %0d", got.size(), first_diff(), want_len);
        end
        checks++;
        if (n_ok != int'(BC) || n_drop != int'(!BC)) begin
            errors++;
            $display("FAIL broadcast_pulses: ok=%0d drop=%0d, want %0d %0d", n_ok, n_drop, BC, !BC);
        end
    endtask

    task automatic test_truncated();
        build(MAC, 4, 0);
        while (fd.size() > 40) void'(fd.pop_back());
        run_frame(-1, 3);
        checks++;
        if (got.size() != 0 || n_ok != 0 || n_drop != 1) begin
            errors++;
            $display("FAIL truncated: out=%0d ok=%0d drop=%0d, want 0 0 1", got.size(), n_ok, n_drop);
        end
        build(MAC, 2, 0);
        model(-1);
        run_frame(-1, 3);
        checks++;
        if (got.size() != 8 || first_diff() != -1 || n_ok != 1 || n_drop != 0) begin
            errors++;
            $display("FAIL after_truncated: out=%0d diff=%0d ok=%0d drop=%0d, want 8 -1 1 0", got.size(), first_diff(), n_ok, n_drop);
        end
    endtask

    task automatic test_reset_mid_frame();
        build(MAC, 100, 0);
        model(HDR + 20);
        run_frame(HDR + 20, 3);
        checks++;
        if (got.size() != 20 || first_diff() != -1 || n_ok != 0) begin
            errors++;
            $display("FAIL reset_mid: out=%0d diff=%0d ok=%0d, want 20 -1 0", got.size(), first_diff(), n_ok);
        end
        build(MAC, 4, 0);
        model(-1);
        run_frame(-1, 3);
        checks++;
        if (got.size() != 16 || first_diff() != -1 || n_ok != 1 || n_drop != 0) begin
            errors++;
            $display("FAIL after_reset: out=%0d diff=%0d ok=%0d drop=%0d, want 16 -1 1 0", got.size(), first_diff(), n_ok, n_drop);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            build(MAC, f + 1, 0);
            model(-1);
            run_frame(-1, 1);
            checks++;
            if (first_diff() != -1 || n_ok != 1 || n_drop != 0 || first_ov != HDR) begin
                errors++;
                $display("FAIL b2b[%0d]: out=%0d diff=%0d ok=%0d drop=%0d first=%0d", f, got.size(), first_diff(), n_ok, n_drop, first_ov);
            end
        end
    endtask

    task automatic test_random();
        logic [47:0] dest;
        int kind, want_first;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 3);
            dest = kind == 0 ? MAC : kind == 1 ? '1 :
                   kind == 2 ? MAC ^ (48'h1 << $urandom_range(0, 47)) : {16'($urandom), 32'($urandom)};
            build(dest, $urandom_range(0, 12), $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                int len = $urandom_range(1, HDR);
                while (fd.size() > len) void'(fd.pop_back());
            end
            model(-1);
            run_frame(-1, $urandom_range(1, 3));
            want_first = exp_q.size() > 0 ? HDR : -1;
            checks++;
            if (first_diff() != -1) begin
                errors++;
                $display("FAIL rand_out[%0d]: got %0d dibits, want %0d, diff at %0d", f, got.size(), exp_q.size(), first_diff());
            end
            checks++;
            if (n_ok != int'(e_ok) || n_drop != int'(e_drop)) begin
                errors++;
                $display("FAIL rand_pulses[%0d]: ok=%0d drop=%0d, want %0d %0d", f, n_ok, n_drop, e_ok, e_drop);
            end
            checks++;
            if (first_ov != want_first || ov_breaks != 0) begin
                errors++;
                $display("FAIL rand_timing[%0d]: first=%0d breaks=%0d, want %0d 0", f, first_ov, ov_breaks, want_first);
            end
        end
    endtask

    initial begin
        test_reset();
        test_match_vector();
        test_mismatch();
        test_broadcast();
        test_truncated();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
